pipe_scroller: RTL and testbench
================================

# pipe_scroller

Generates and scrolls the single on-screen pipe obstacle, and feeds `pipe_x`/`pipe_y` to the game controller and the collision logic. Once per video frame it moves the pipe left by a fixed speed. When the pipe leaves the screen it respawns at the right edge with a pseudo-random gap height from an internal LFSR. It also pulses when the pipe clears the bird column and keeps a saturating score.

## Interface
- `SCREEN_WIDTH`, 640, respawn x position and horizontal extent
- `SCREEN_HEIGHT`, 480, vertical extent; requires `GAP_Y_MAX + PIPE_GAP <= SCREEN_HEIGHT`
- `PIPE_WIDTH`, 50, pipe width in pixels
- `PIPE_GAP`, 100, vertical gap height (range check only)
- `PIPE_SPEED`, 2, pixels moved per frame tick, 1..15
- `GAP_Y_MIN`, 40, smallest gap top y
- `GAP_Y_MAX`, 340, largest gap top y; requires `511 < 2*(GAP_Y_MAX-GAP_Y_MIN+1)`
- `BIRD_X`, 100, x of the bird's left edge, used for pass detection
- `LFSR_SEED`, 16'hACE1, LFSR value loaded on reset; must be nonzero
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `restart` in 1: one-cycle pulse; returns the block to IDLE and clears the score
- `play` in 1: level input, high while the game is in play
- `frame_tick` in 1: one-cycle pulse per video frame
- `pipe_x` out 10: pipe left edge x
- `pipe_y` out 9: gap top y
- `pipe_valid` out 1: pipe is on screen
- `pipe_passed` out 1: one-cycle pulse when the pipe's right edge passes `BIRD_X`
- `score` out 8: count of pipes passed, saturates at 255

## Operation
- **States:** IDLE, SCROLL, HOLD.
- **Transitions (priority order):**
  - `restart`, from any state → IDLE.
  - IDLE with `play` → SCROLL. On this transition load `pipe_x=SCREEN_WIDTH` and `pipe_y=gap(lfsr)`.
  - SCROLL with `!play` → HOLD.
  - HOLD with `play` → SCROLL. Position and gap are unchanged.
- **Movement:** occurs only when state is SCROLL, `play` is high and `frame_tick` is high in the same cycle.
  - If `pipe_x < PIPE_SPEED`: respawn with `pipe_x=SCREEN_WIDTH` and `pipe_y=gap(lfsr)`.
  - Otherwise: `pipe_x = pipe_x - PIPE_SPEED`.
- **Pass detection:** on a movement step (not a respawn), if `old_x+PIPE_WIDTH >= BIRD_X` and `new_x+PIPE_WIDTH < BIRD_X`:
  - `pipe_passed` pulses.
  - `score` increments unless it is already 255.
  - Compute the sums in 11 bits.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, shifts every clock in all states.
  - Reseeded only by `reset`; `restart` does not touch it.
- **Gap mapping:** `r = lfsr[8:0]`.
  - If `r > GAP_Y_MAX-GAP_Y_MIN`, subtract `GAP_Y_MAX-GAP_Y_MIN+1`.
  - `gap = GAP_Y_MIN + r`. The result always lies in [GAP_Y_MIN, GAP_Y_MAX].
- **`pipe_valid`:** 1 in SCROLL and HOLD, 0 in IDLE.
- **In IDLE:** `pipe_x=SCREEN_WIDTH`, `pipe_y=GAP_Y_MIN`.

## Timing
- All outputs are registered; changes are visible the cycle after the causing input.
- **Reset values:** state IDLE, `pipe_x=640`, `pipe_y=GAP_Y_MIN` (40), `pipe_valid=0`, `pipe_passed=0`, `score=0`, lfsr=`LFSR_SEED`.
- **`restart` takes effect in one cycle:**
  - Same outputs as reset, except the LFSR keeps running.
  - Overrides a coincident `frame_tick` and `play`.
- **`frame_tick` coinciding with the IDLE→SCROLL transition** is ignored: the first move happens on the next tick.
- **`frame_tick` in the same cycle `play` drops** in SCROLL: no move; state → HOLD.
- `pipe_passed` is high for exactly one cycle per pass and never fires on the respawn step.
- **Back-to-back `frame_tick`s** (every cycle) are legal: one move per cycle.

## Test plan
- **Reset and idle:** reset, then hold `play=0` for 10 cycles → `pipe_x=640`, `pipe_y=40`, `pipe_valid=0`, `score=0` throughout.
- **Start and scroll:** `play=1`, then 10 `frame_tick`s → `pipe_valid=1`, `pipe_x=620`, and `pipe_y` within 40..340 matching the LFSR reference model.
- **Pass:** continue ticking → `pipe_passed` pulses once, on the tick that takes x 50→48 (tick 296 overall), and `score=1`.
- **Respawn:** continue ticking → tick 321 sees x=0, `pipe_x` returns to 640, a new `pipe_y` in range, and no `pipe_passed` on that tick.
- **Pause:** drop `play` mid-scroll at x=400 while ticking 20 times → x stays 400. Raise `play` again and tick once → x=398.
- **Restart priority and saturation:**
  - Force 255 passes → `score` holds at 255 after the 256th pass.
  - `restart` together with `frame_tick` → next cycle IDLE, x=640, `score=0`, `pipe_valid=0`.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls the single pipe obstacle left once per frame,
// respawns it with an LFSR-derived gap height and keeps a saturating score.
module pipe_scroller #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          PIPE_WIDTH    = 50,
    parameter int          PIPE_GAP      = 100,
    parameter int          PIPE_SPEED    = 2,
    parameter int          GAP_Y_MIN     = 40,
    parameter int          GAP_Y_MAX     = 340,
    parameter int          BIRD_X        = 100,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       play,
    input  logic       frame_tick,
    output logic [9:0] pipe_x,
    output logic [8:0] pipe_y,
    output logic       pipe_valid,
    output logic       pipe_passed,
    output logic [7:0] score
);

    // Parameter sanity, caught at elaboration.
    if (PIPE_SPEED < 1 || PIPE_SPEED > 15) begin : g_bad_speed
        $error("PIPE_SPEED must be 1..15");
    end
    if (GAP_Y_MAX + PIPE_GAP > SCREEN_HEIGHT) begin : g_bad_gap
        $error("gap does not fit on screen");
    end
    if (2 * (GAP_Y_MAX - GAP_Y_MIN + 1) <= 511) begin : g_bad_span
        $error("gap span too small for a single fold");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    localparam logic [9:0]  RESPAWN_X = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  SPEED_X   = 10'(PIPE_SPEED);
    localparam logic [10:0] WIDTH_X   = 11'(PIPE_WIDTH);
    localparam logic [10:0] BIRD_EDGE = 11'(BIRD_X);
    localparam logic [8:0]  GAP_MIN   = 9'(GAP_Y_MIN);
    localparam logic [8:0]  GAP_SPAN  = 9'(GAP_Y_MAX - GAP_Y_MIN);
    localparam logic [8:0]  GAP_RANGE = 9'(GAP_Y_MAX - GAP_Y_MIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        HOLD
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [8:0]  gap_r;
    logic [8:0]  gap_y;
    logic [9:0]  step_x;
    logic [10:0] old_edge;
    logic [10:0] new_edge;
    logic        respawn;
    logic        crossed;

    // LFSR feedback, gap folding and the next-step geometry.
    always_comb begin
        lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        gap_r    = lfsr[8:0];
        if (gap_r > GAP_SPAN) begin
            gap_r = gap_r - GAP_RANGE;
        end
        gap_y    = GAP_MIN + gap_r;
        respawn  = pipe_x < SPEED_X;
        step_x   = pipe_x - SPEED_X;
        old_edge = {1'b0, pipe_x} + WIDTH_X;
        new_edge = {1'b0, step_x} + WIDTH_X;
        crossed  = (old_edge >= BIRD_EDGE) && (new_edge < BIRD_EDGE);
    end

    // Free-running LFSR; only a hard reset reseeds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Game FSM with registered pipe position, pass pulse and score.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state       <= IDLE;
            pipe_x      <= RESPAWN_X;
            pipe_y      <= GAP_MIN;
            pipe_valid  <= 1'b0;
            pipe_passed <= 1'b0;
            score       <= 8'd0;
        end else begin
            pipe_passed <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (play) begin
                        state      <= SCROLL;
                        pipe_x     <= RESPAWN_X;
                        pipe_y     <= gap_y;
                        pipe_valid <= 1'b1;
                    end
                end
                SCROLL: begin
                    if (!play) begin
                        state <= HOLD;
                    end else if (frame_tick) begin
                        if (respawn) begin
                            pipe_x <= RESPAWN_X;
                            pipe_y <= gap_y;
                        end else begin
                            pipe_x <= step_x;
                            if (crossed) begin
                                pipe_passed <= 1'b1;
                                if (score != 8'hFF) begin
                                    score <= score + 8'd1;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (play) begin
                        state <= SCROLL;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: scoreboard bench for pipe_scroller, running a default
// instance and a fast instance against a behavioural game model.
module tb_pipe_scroller;

    localparam int          W    = 640;
    localparam int          PW   = 50;
    localparam int          BX   = 100;
    localparam int          GMIN = 40;
    localparam int          GMAX = 340;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int x;
        int y;
        bit valid;
        bit passed;
        int score;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       play = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] px0, px1;
    logic [8:0] py0, py1;
    logic       v0, v1, pp0, pp1;
    logic [7:0] sc0, sc1;

    int tests = 0;
    int fails = 0;

    int spd[2] = '{2, 15};
    int md[2], mx[2], my[2], msc[2];
    bit mpass[2];
    logic [15:0] mlfsr = SEED;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pipe_scroller dut (
        .clk(clk), .reset(reset), .restart(restart),
        .play(play), .frame_tick(frame_tick),
        .pipe_x(px0), .pipe_y(py0), .pipe_valid(v0),
        .pipe_passed(pp0), .score(sc0)
    );

    pipe_scroller #(.PIPE_SPEED(15)) dut_fast (
        .clk(clk), .reset(reset), .restart(restart),
        .play(play), .frame_tick(frame_tick),
        .pipe_x(px1), .pipe_y(py1), .pipe_valid(v1),
        .pipe_passed(pp1), .score(sc1)
    );

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gap_of(logic [15:0] l);
        int r;
        r = int'(l[8:0]);
        if (r > GMAX - GMIN) r = r - (GMAX - GMIN + 1);
        return GMIN + r;
    endfunction

    function automatic logic [15:0] lfsr_next(logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // md: 0 = not in game, 1 = scrolling, 2 = paused
    task automatic model_lane(int l, bit r, bit rs, bit pl, bit ft, int g);
        int nx;
        mpass[l] = 0;
        if (r || rs) begin
            md[l] = 0; mx[l] = W; my[l] = GMIN; msc[l] = 0;
        end else if (md[l] == 0) begin
            if (pl) begin
                md[l] = 1; mx[l] = W; my[l] = g;
            end
        end else if (!pl) begin
            md[l] = 2;
        end else if (md[l] == 2) begin
            md[l] = 1;
        end else if (ft) begin
            if (mx[l] < spd[l]) begin
                mx[l] = W; my[l] = g;
            end else begin
                nx = mx[l] - spd[l];
                if (mx[l] + PW >= BX && nx + PW < BX) begin
                    mpass[l] = 1;
                    if (msc[l] < 255) msc[l]++;
                end
                mx[l] = nx;
            end
        end
    endtask

    task automatic step(bit r, bit rs, bit pl, bit ft);
        int g;
        @(negedge clk);
        reset = r; restart = rs; play = pl; frame_tick = ft;
        g = gap_of(mlfsr);
        model_lane(0, r, rs, pl, ft, g);
        model_lane(1, r, rs, pl, ft, g);
        mlfsr = r ? SEED : lfsr_next(mlfsr);
        @(posedge clk);
        q0.push_back('{mx[0], my[0], md[0] != 0, mpass[0], msc[0]});
        q1.push_back('{mx[1], my[1], md[1] != 0, mpass[1], msc[1]});
        #1;
    endtask

    // Monitor: every cycle the DUT presents fresh registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("x0", int'(px0), e.x);
                chk("y0", int'(py0), e.y);
                chk("valid0", int'(v0), int'(e.valid));
                chk("passed0", int'(pp0), int'(e.passed));
                chk("score0", int'(sc0), e.score);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("x1", int'(px1), e.x);
                chk("y1", int'(py1), e.y);
                chk("valid1", int'(v1), int'(e.valid));
                chk("passed1", int'(pp1), int'(e.passed));
                chk("score1", int'(sc1), e.score);
            end
        end
    end

    initial begin
        int ticks;
        int npass;
        int budget;
        repeat (3) step(1, 0, 0, 0);
        chk("reset_x", int'(px0), 640);
        chk("reset_y", int'(py0), 40);
        chk("reset_valid", int'(v0), 0);
        repeat (10) step(0, 0, 0, 1'($urandom % 2));
        chk("idle_x", int'(px0), 640);
        chk("idle_score", int'(sc0), 0);

        // Start with a coincident tick, which must be ignored.
        step(0, 0, 1, 1);
        chk("start_x", int'(px0), 640);
        chk("start_valid", int'(v0), 1);

        ticks = 0;
        npass = 0;
        repeat (330) begin
            step(0, 0, 1, 1);
            ticks++;
            npass += int'(pp0);
            if (ticks == 10) begin
                chk("tick10_x", int'(px0), 620);
                chk("tick10_y_range",
                    int'(py0 >= 9'd40 && py0 <= 9'd340), 1);
            end
            if (ticks == 295) chk("pre_pass_count", npass, 0);
            if (ticks == 296) begin
                chk("pass_pulse", int'(pp0), 1);
                chk("pass_x", int'(px0), 48);
                chk("pass_score", int'(sc0), 1);
            end
            if (ticks == 321) begin
                chk("respawn_x", int'(px0), 640);
                chk("respawn_nopass", int'(pp0), 0);
                chk("respawn_y_range",
                    int'(py0 >= 9'd40 && py0 <= 9'd340), 1);
            end
        end
        chk("pass_count", npass, 1);

        budget = 0;
        while (mx[0] != 400 && budget < 400) begin
            step(0, 0, 1, 1);
            budget++;
        end
        chk("pause_reach_400", int'(px0), 400);
        repeat (20) step(0, 0, 0, 1);
        chk("pause_hold_x", int'(px0), 400);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("resume_x", int'(px0), 398);

        repeat (3000) begin
            step(0, 1'($urandom % 300 == 0),
                 1'($urandom % 20 != 0), 1'($urandom % 4 != 0));
        end

        // Saturation on the fast instance.
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        npass = 0;
        budget = 0;
        while (npass < 257 && budget < 20000) begin
            step(0, 0, 1, 1);
            npass += int'(pp1);
            budget++;
        end
        chk("sat_passes", npass, 257);
        chk("sat_score", int'(sc1), 255);

        step(0, 1, 1, 1);
        chk("restart_x", int'(px0), 640);
        chk("restart_score", int'(sc0), 0);
        chk("restart_valid", int'(v0), 0);
        chk("restart_score_fast", int'(sc1), 0);
        repeat (4) step(0, 0, 0, 1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
